// File: rtl/mem_bridge_pkg.sv
// Shared constants for the CPU-to-memory bridge: state encoding, widths and the
// read value returned after an aborted access.
`ifndef WIDTH
`define WIDTH 32
`endif

package mem_bridge_pkg;

    localparam int ADDR_W_DEF = `WIDTH;
    localparam int DATA_W_DEF = `WIDTH;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

    function automatic logic is_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_bridge_timer.sv
// Counts cycles spent waiting for a memory ack and flags the abort cycle.
// Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_bridge_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // Count is 0 in the first wait cycle, so this fires in wait cycle TIMEOUT.
    assign expired_o = en_i && (cnt_q == 8'(TIMEOUT - 1));

endmodule

// File: rtl/mem_bridge.sv
// Turns level MemRd/MemWr strobes into a registered req/ack memory handshake
// and stalls the multicycle controller meanwhile. Optional: MEM_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | no access; a strobe stalls and starts one at the next edge
// REQ     | mem_req held, waiting for mem_ack (or timeout)
// DONE    | one unstalled cycle so the controller advances; strobes ignored
module mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              err
);

    if (TIMEOUT < 2 || TIMEOUT > 256) begin : g_bad_timeout
        $error("mem_bridge: TIMEOUT must lie in 2..256");
    end

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;

    logic strobe;
    logic aligned;
    logic start_req;
    logic timeout_hit;

    assign strobe    = cpu_rd | cpu_wr;
    assign aligned   = is_aligned(cpu_addr[1:0]);
    assign start_req = (state_q == ST_IDLE) && strobe && aligned;

`ifdef MEM_TIMEOUT_EN
    mem_bridge_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start_req),
        .en_i      (state_q == ST_REQ),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    // rd+wr together resolves to a write but is still an error
                    if (cpu_rd && cpu_wr)
                        err_d = 1'b1;
                    if (!aligned) begin
                        err_d = 1'b1;
                        if (!cpu_wr)
                            rdata_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                        we_d    = cpu_wr;
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    req_d = 1'b0;
                    if (!we_q)
                        rdata_d = mem_rdata;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                    if (!we_q)
                        rdata_d = DATA_W'(ERR_RDATA);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_stall = ((state_q == ST_IDLE) && strobe) || (state_q == ST_REQ);
    assign cpu_rdata = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign err       = err_q;

endmodule
